// File: rtl/pwm_setpoint_ramp.sv
// Slew-rate limited setpoint for a high-resolution PWM stage: the compare code walks
// toward the most recently accepted target by at most one step per PWM period.
module pwm_setpoint_ramp #(
  parameter int WIDTH  = 20,
  parameter int HRBITS = 3,
  parameter int DSBITS = 5,
  parameter int PERIOD = 'hff,
  parameter int STEPW  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH+DSBITS-1:0]   tgt_data,
  input  logic                      tgt_valid,
  output logic                      tgt_ready,
  input  logic [STEPW-1:0]          step,
  input  logic                      prd_tick,
  output logic [WIDTH-1:0]          cmpA,
  output logic [DSBITS-1:0]         ds_fraction,
  output logic                      busy,
  output logic                      clamped
);

  localparam int CW = WIDTH + DSBITS;
  localparam logic [CW-1:0] MAXCODE = CW'((PERIOD + 1) << (HRBITS + DSBITS));

  typedef enum logic {
    IDLE,
    RAMP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cur_q, cur_d;
  logic [CW-1:0] tgt_q, tgt_d;
  logic          clamped_q, clamped_d;
  logic          ready_q;

  logic          transfer;
  logic          overRange;
  logic [CW:0]   stepExt;
  logic [CW:0]   sumExt;
  logic [CW:0]   diffExt;
  logic [CW:0]   tgtExt;

  assign transfer  = tgt_valid && ready_q;
  assign overRange = (tgt_data > MAXCODE);
  assign stepExt   = (CW+1)'(step);
  assign tgtExt    = {1'b0, tgt_q};
  // One extra bit keeps the sum from wrapping and exposes a borrow below zero.
  assign sumExt    = {1'b0, cur_q} + stepExt;
  assign diffExt   = {1'b0, cur_q} - stepExt;

  always_comb begin
    tgt_d     = tgt_q;
    clamped_d = clamped_q;
    if (transfer) begin
      tgt_d = overRange ? MAXCODE : tgt_data;
      if (overRange) begin
        clamped_d = 1'b1;
      end
    end
  end

  // The tick update deliberately uses the target held before this edge.
  always_comb begin
    cur_d = cur_q;
    if (prd_tick) begin
      if (step == '0) begin
        cur_d = tgt_q;
      end else if (cur_q < tgt_q) begin
        cur_d = (sumExt > tgtExt) ? tgt_q : sumExt[CW-1:0];
      end else if (cur_q > tgt_q) begin
        cur_d = (diffExt[CW] || (diffExt < tgtExt)) ? tgt_q : diffExt[CW-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if ((tgt_q != cur_q) && (cur_d != tgt_d)) begin
          state_d = RAMP;
        end
      end
      RAMP: begin
        if (cur_d == tgt_d) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cur_q     <= '0;
      tgt_q     <= '0;
      clamped_q <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      tgt_q     <= tgt_d;
      clamped_q <= clamped_d;
      ready_q   <= 1'b1;
    end
  end

  assign tgt_ready   = ready_q;
  assign cmpA        = cur_q[CW-1:DSBITS];
  assign ds_fraction = cur_q[DSBITS-1:0];
  assign busy        = (state_q == RAMP);
  assign clamped     = clamped_q;

endmodule

// File: tb/tb_pwm_setpoint_ramp.sv
// Directed bench for pwm_setpoint_ramp: each task drives one scenario and checks
// the setpoint code, busy, clamped and ready against hand-computed values.
module tb_pwm_setpoint_ramp;

  logic        clk;
  logic        rst;
  logic [24:0] tgt_data;
  logic        tgt_valid;
  logic        tgt_ready;
  logic [15:0] step;
  logic        prd_tick;
  logic [19:0] cmpA;
  logic [4:0]  ds_fraction;
  logic        busy;
  logic        clamped;

  int errors = 0;
  int checks = 0;

  logic [24:0] curObs;
  assign curObs = {cmpA, ds_fraction};

  pwm_setpoint_ramp dut (
    .clk        (clk),
    .rst        (rst),
    .tgt_data   (tgt_data),
    .tgt_valid  (tgt_valid),
    .tgt_ready  (tgt_ready),
    .step       (step),
    .prd_tick   (prd_tick),
    .cmpA       (cmpA),
    .ds_fraction(ds_fraction),
    .busy       (busy),
    .clamped    (clamped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doTransfer(input logic [24:0] data);
    tgt_data  = data;
    tgt_valid = 1'b1;
    cycle();
    tgt_valid = 1'b0;
  endtask

  task automatic pulseTick();
    prd_tick = 1'b1;
    cycle();
    prd_tick = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({cmpA, ds_fraction, busy, clamped, tgt_ready} !== 28'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h expected 0", {cmpA, ds_fraction, busy, clamped, tgt_ready});
    end
    rst = 1'b0;
    #1;
    checks++;
    if (tgt_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ready_before_edge: got %b expected 0", tgt_ready);
    end
    cycle();
    checks++;
    if (tgt_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ready_after_edge: got %b expected 1", tgt_ready);
    end
  endtask

  task automatic test_ramp_up();
    step = 16'd1024;
    doTransfer(25'd4096);
    checks++;
    if (curObs !== 25'd0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ramp_transfer_edge: got cur=%0d busy=%b expected cur=0 busy=0", curObs, busy);
    end
    cycle();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ramp_busy_rise: got %b expected 1", busy);
    end
    for (int i = 1; i <= 4; i++) begin
      pulseTick();
      checks++;
      if (curObs !== 25'(i * 1024) || busy !== (i < 4)) begin
        errors++;
        $display("[TB] FAIL ramp_tick%0d: got cur=%0d busy=%b expected cur=%0d busy=%b", i, curObs, busy, i * 1024, (i < 4));
      end
      if (i == 1) begin
        cycle();
        cycle();
        checks++;
        if (curObs !== 25'd1024) begin
          errors++;
          $display("[TB] FAIL ramp_hold_between_ticks: got %0d expected 1024", curObs);
        end
      end
    end
    checks++;
    if (cmpA !== 20'd128 || ds_fraction !== 5'd0) begin
      errors++;
      $display("[TB] FAIL ramp_final_cmpA: got cmpA=%0d ds=%0d expected cmpA=128 ds=0", cmpA, ds_fraction);
    end
  endtask

  task automatic test_overshoot();
    step = 16'd3000;
    doTransfer(25'd1000);
    cycle();
    pulseTick();
    checks++;
    if (curObs !== 25'd1096 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL overshoot_first: got cur=%0d busy=%b expected cur=1096 busy=1", curObs, busy);
    end
    pulseTick();
    checks++;
    if (curObs !== 25'd1000 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL overshoot_second: got cur=%0d busy=%b expected cur=1000 busy=0", curObs, busy);
    end
  endtask

  task automatic test_clamp();
    step = 16'd0;
    checks++;
    if (clamped !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clamp_initial: got %b expected 0", clamped);
    end
    doTransfer(25'h1FFFFFF);
    checks++;
    if (clamped !== 1'b1) begin
      errors++;
      $display("[TB] FAIL clamp_flag: got %b expected 1", clamped);
    end
    cycle();
    pulseTick();
    checks++;
    if (curObs !== 25'd65536 || cmpA !== 20'd2048 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clamp_value: got cur=%0d cmpA=%0d busy=%b expected cur=65536 cmpA=2048 busy=0", curObs, cmpA, busy);
    end
    doTransfer(25'd100);
    cycle();
    pulseTick();
    checks++;
    if (curObs !== 25'd100 || clamped !== 1'b1) begin
      errors++;
      $display("[TB] FAIL clamp_sticky: got cur=%0d clamped=%b expected cur=100 clamped=1", curObs, clamped);
    end
  endtask

  task automatic test_simultaneous();
    step = 16'd0;
    doTransfer(25'd0);
    cycle();
    pulseTick();
    step = 16'd200;
    tgt_data  = 25'd500;
    tgt_valid = 1'b1;
    prd_tick  = 1'b1;
    cycle();
    tgt_valid = 1'b0;
    prd_tick  = 1'b0;
    checks++;
    if (curObs !== 25'd0) begin
      errors++;
      $display("[TB] FAIL simul_same_edge: got %0d expected 0", curObs);
    end
    cycle();
    pulseTick();
    checks++;
    if (curObs !== 25'd200) begin
      errors++;
      $display("[TB] FAIL simul_next_tick: got %0d expected 200", curObs);
    end
    pulseTick();
    pulseTick();
    checks++;
    if (curObs !== 25'd500 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL simul_settle: got cur=%0d busy=%b expected cur=500 busy=0", curObs, busy);
    end
  endtask

  task automatic test_retarget();
    step = 16'd0;
    doTransfer(25'd0);
    cycle();
    pulseTick();
    step = 16'd1000;
    doTransfer(25'd8000);
    cycle();
    for (int i = 0; i < 3; i++) pulseTick();
    checks++;
    if (curObs !== 25'd3000 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL retarget_mid: got cur=%0d busy=%b expected cur=3000 busy=1", curObs, busy);
    end
    doTransfer(25'd2000);
    pulseTick();
    checks++;
    if (curObs !== 25'd2000 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL retarget_down: got cur=%0d busy=%b expected cur=2000 busy=0", curObs, busy);
    end
  endtask

  task automatic test_transfer_equal();
    step = 16'd1000;
    doTransfer(25'd5000);
    cycle();
    pulseTick();
    doTransfer(25'd3000);
    checks++;
    if (busy !== 1'b0 || curObs !== 25'd3000) begin
      errors++;
      $display("[TB] FAIL equal_transfer_idle: got cur=%0d busy=%b expected cur=3000 busy=0", curObs, busy);
    end
    pulseTick();
    checks++;
    if (curObs !== 25'd3000) begin
      errors++;
      $display("[TB] FAIL equal_transfer_hold: got %0d expected 3000", curObs);
    end
  endtask

  task automatic test_back_to_back_ticks();
    step = 16'd1000;
    doTransfer(25'd6000);
    cycle();
    prd_tick = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      cycle();
      checks++;
      if (curObs !== 25'(3000 + i * 1000)) begin
        errors++;
        $display("[TB] FAIL held_tick%0d: got %0d expected %0d", i, curObs, 3000 + i * 1000);
      end
    end
    prd_tick = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL held_tick_idle: got %b expected 0", busy);
    end
  endtask

  task automatic test_reset_midramp();
    step = 16'd1000;
    doTransfer(25'd10000);
    cycle();
    pulseTick();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({cmpA, ds_fraction, busy, clamped, tgt_ready} !== 28'd0) begin
      errors++;
      $display("[TB] FAIL reset_async: got %h expected 0", {cmpA, ds_fraction, busy, clamped, tgt_ready});
    end
    #1;
    rst = 1'b0;
    cycle();
    for (int i = 0; i < 3; i++) pulseTick();
    checks++;
    if (curObs !== 25'd0 || busy !== 1'b0 || tgt_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_discard: got cur=%0d busy=%b ready=%b expected cur=0 busy=0 ready=1", curObs, busy, tgt_ready);
    end
  endtask

  initial begin
    rst       = 1'b1;
    tgt_data  = '0;
    tgt_valid = 1'b0;
    step      = '0;
    prd_tick  = 1'b0;
    test_reset();
    test_ramp_up();
    test_overshoot();
    test_clamp();
    test_simultaneous();
    test_retarget();
    test_transfer_equal();
    test_back_to_back_ticks();
    test_reset_midramp();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
